// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared types and constants for the iterative divider
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring shift-subtract step
module div_iter_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    // q_in carries unconsumed dividend bits at the top and quotient bits at the bottom
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_out = shifted[WIDTH-1:0] - divisor;
            q_out   = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             e_stall,
    input  logic             e_flush,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q, dq_q, divisor_q;
    logic [WIDTH-1:0] rem_step, dq_step;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             neg_quo, neg_rem;
    logic             start, finish;

    assign a_abs  = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs  = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign start  = (state == DIV_IDLE) && (state_next == DIV_BUSY);
    assign finish = (state == DIV_BUSY) && (state_next == DIV_DONE);

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .q_in    (dq_q),
        .divisor (divisor_q),
        .rem_out (rem_step),
        .q_out   (dq_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    // Flush wins everywhere; losing div_en mid-iteration is treated as an abort
    always_comb begin
        state_next = state;
        if (e_flush) begin
            state_next = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (div_en) state_next = DIV_BUSY;
                DIV_BUSY: begin
                    if (!div_en)            state_next = DIV_IDLE;
                    else if (count == LAST) state_next = DIV_DONE;
                end
                DIV_DONE: if (!e_stall) state_next = DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        div_ready = (state == DIV_DONE);
        busy      = (state == DIV_BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            divisor_q <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (start) begin
                rem_q     <= '0;
                dq_q      <= a_abs;
                divisor_q <= b_abs;
                neg_quo   <= div_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_rem   <= div_signed & src_a[WIDTH-1];
            end else if (state == DIV_BUSY && state_next != DIV_IDLE) begin
                rem_q <= rem_step;
                dq_q  <= dq_step;
            end

            if (state == DIV_BUSY && state_next == DIV_BUSY) count <= count + 1'b1;
            else                                             count <= '0;

            if (finish) begin
                quotient  <= neg_quo ? -dq_step : dq_step;
                remainder <= neg_rem ? -rem_step : rem_step;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter against an arithmetic reference
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        div_en;
    logic        div_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        e_stall;
    logic        e_flush;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_en     (div_en),
        .div_signed (div_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .e_stall    (e_stall),
        .e_flush    (e_flush),
        .div_ready  (div_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ua, ub;
        ua = (s && a[31]) ? 32'(-a) : a;
        ub = (s && b[31]) ? 32'(-b) : b;
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (s && (a[31] ^ b[31])) q = 32'(-q);
        if (s && a[31])           r = 32'(-r);
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output logic [31:0] q, output logic [31:0] r);
        src_a = a; src_b = b; div_signed = s; div_en = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                src_a = $urandom;
                src_b = $urandom;
            end
        end while (!div_ready && lat < 100);
        q = quotient;
        r = remainder;
    endtask

    task automatic release_and_check(input string name);
        div_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (div_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_drop: got %b expected 0", name, div_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; div_en = 1'b0; div_signed = 1'b0; src_a = '0; src_b = '0;
        e_stall = 1'b0; e_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({div_ready, busy, quotient, remainder} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b busy=%b q=%h r=%h expected all 0",
                     div_ready, busy, quotient, remainder);
        end
        rst = 1'b0;
        src_a = 32'd55; src_b = 32'd5;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if ({div_ready, busy, quotient} !== 34'd0) begin
            n_fail++;
            $display("FAIL idle_no_en: got ready=%b busy=%b q=%h expected 0", div_ready, busy, quotient);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
        logic [31:0] tb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] eq [6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5, 32'hFFFF_FFF9};
        int lat;
        logic [31:0] q, r;
        for (int i = 0; i < 6; i++) begin
            run_div(ta[i], tb[i], ts[i], lat, q, r);
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL directed%0d latency: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (q !== eq[i] || r !== er[i]) begin
                n_fail++;
                $display("FAIL directed%0d result: got q=%h r=%h expected q=%h r=%h", i, q, r, eq[i], er[i]);
            end
            release_and_check($sformatf("directed%0d", i));
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a, b, q, r, eq, er;
        logic s;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er);
            run_div(a, b, s, lat, q, r);
            n_checks++;
            if (lat !== 33 || q !== eq || r !== er) begin
                n_fail++;
                $display("FAIL random%0d %h/%h s=%b: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                         i, a, b, s, lat, q, r, eq, er);
            end
            release_and_check($sformatf("random%0d", i));
        end
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] q, r;
        logic seen;
        src_a = 32'd1000; src_b = 32'd3; div_signed = 1'b0; div_en = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_before: got %b expected 1", busy);
        end
        e_flush = 1'b1;
        @(posedge clk); #1;
        e_flush = 1'b0; div_en = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || div_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_to_idle: got busy=%b ready=%b expected 0 0", busy, div_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_ready) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ready: got %b expected 0", seen);
        end
        run_div(32'd9, 32'd3, 1'b0, lat, q, r);
        n_checks++;
        if (lat !== 33 || q !== 32'd3 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_restart: got lat=%0d q=%h r=%h expected lat=33 q=3 r=0", lat, q, r);
        end
        release_and_check("flush_restart");
    endtask

    task automatic test_stall();
        int lat;
        logic [31:0] a, b, q, r, eq, er;
        a = $urandom; b = 32'($urandom_range(1, 999));
        ref_div(a, b, 1'b0, eq, er);
        e_stall = 1'b1;
        run_div(a, b, 1'b0, lat, q, r);
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 33", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (div_ready !== 1'b1 || quotient !== eq || remainder !== er) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got ready=%b q=%h r=%h expected ready=1 q=%h r=%h",
                         i, div_ready, quotient, remainder, eq, er);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        e_stall = 1'b0;
        release_and_check("stall");
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a, b, q, r, eq, er;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = 32'($urandom_range(1, 70000));
            ref_div(a, b, 1'b0, eq, er);
            run_div(a, b, 1'b0, lat, q, r);
            n_checks++;
            if (lat !== (i == 0 ? 33 : 34) || q !== eq || r !== er) begin
                n_fail++;
                $display("FAIL b2b%0d: got lat=%0d q=%h r=%h expected lat=%0d q=%h r=%h",
                         i, lat, q, r, (i == 0 ? 33 : 34), eq, er);
            end
        end
        release_and_check("b2b");
    endtask

    task automatic test_async_reset();
        int lat;
        logic [31:0] q, r;
        src_a = 32'hDEAD_BEEF; src_b = 32'd17; div_signed = 1'b0; div_en = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({div_ready, busy, quotient, remainder} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b busy=%b q=%h r=%h expected all 0",
                     div_ready, busy, quotient, remainder);
        end
        div_en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_div(32'd1234567, 32'd1000, 1'b0, lat, q, r);
        n_checks++;
        if (lat !== 33 || q !== 32'd1234 || r !== 32'd567) begin
            n_fail++;
            $display("FAIL reset_restart: got lat=%0d q=%h r=%h expected lat=33 q=4d2 r=237", lat, q, r);
        end
        release_and_check("reset_restart");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
